// File: rtl/aucohl_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aucohl_uart_pkg
// Description : Shared UART types, state encoding, frame constants and parity.
// Revision    : 1.0 - initial release
// ============================================================================
package aucohl_uart_pkg;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_START  = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_PARITY = 3'd3;
    localparam logic [2:0] C_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = C_ST_IDLE,
        S_START  = C_ST_START,
        S_DATA   = C_ST_DATA,
        S_PARITY = C_ST_PARITY,
        S_STOP   = C_ST_STOP
    } state_t;

    localparam int C_MIN_DW        = 5;
    localparam int C_MAX_DW        = 8;
    localparam int C_START_BITS    = 1;
    localparam int C_MIN_STOP_BITS = 1;

    // Frame length in bit periods; multiply by (prescale+1) for clk cycles.
    function automatic int frame_bits(input int dw, input logic par_en, input logic stop2);
        return C_START_BITS + dw + int'(par_en) + C_MIN_STOP_BITS + int'(stop2);
    endfunction

    // Narrower words are zero-extended by the caller; that leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [C_MAX_DW-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aucohl_uart_baud.sv
`default_nettype none
// ============================================================================
// Module      : aucohl_uart_baud
// Description : Bit-period down-counter with synchronous reload and bit_end strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module aucohl_uart_baud #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reload,
    input  logic [PW-1:0] load_val,
    output logic          bit_end
);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (reload) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PW'(1);
        end
    end

    assign bit_end = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/aucohl_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : aucohl_uart_tx
// Description : UART transmitter draining a fall-through FIFO, one pop per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module aucohl_uart_tx
    import aucohl_uart_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] prescale,
    input  logic          parity_en,
    input  logic          parity_odd,
    input  logic          stop2,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int              C_IW       = $clog2(DW);
    localparam logic [C_IW-1:0] C_LAST_IDX = C_IW'(DW - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_shift;
    logic [DW-1:0]   w_shift_next;
    logic [C_IW-1:0] r_idx;
    logic [C_IW-1:0] w_idx_next;
    logic            r_stop_cnt;
    logic            w_stop_cnt_next;
    logic            r_par_en;
    logic            r_stop2;
    logic            r_par_bit;
    logic [PW-1:0]   r_prescale;
    logic            r_tx;
    logic            w_tx_next;

    logic            w_bit_end;
    logic            w_active;
    logic            w_last;
    logic            w_pop;
    logic            w_reload;
    logic [PW-1:0]   w_load_val;

    assign w_active = (r_state != S_IDLE);
    assign w_last   = (r_state == S_STOP) & w_bit_end & (~r_stop2 | r_stop_cnt);
    // Reset gates the pop so no word is consumed in a cycle that is about to be discarded.
    assign w_pop    = en & ~fifo_empty & ~rst & ((r_state == S_IDLE) | w_last);

    // On a pop the live prescale is used so the first bit already runs at the new rate.
    assign w_reload   = w_pop | (w_active & w_bit_end);
    assign w_load_val = w_pop ? prescale : r_prescale;

    aucohl_uart_baud #(
        .PW (PW)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .reload   (w_reload),
        .load_val (w_load_val),
        .bit_end  (w_bit_end)
    );

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_idx_next      = r_idx;
        w_stop_cnt_next = r_stop_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == C_LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_next = r_idx + C_IW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_cnt) begin
                        w_stop_cnt_next = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b0;
                        w_state_next    = w_pop ? S_START : S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_pop) begin
            w_shift_next = fifo_rdata;
        end

        // tx is registered, so it follows the state being entered.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_par_bit;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_prescale <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_shift    <= w_shift_next;
            r_idx      <= w_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            if (w_pop) begin
                r_par_en   <= parity_en;
                r_stop2    <= stop2;
                r_prescale <= prescale;
                r_par_bit  <= parity_bit(C_MAX_DW'(fifo_rdata), parity_odd);
            end
        end
    end

    assign fifo_rd = w_pop;
    assign tx      = r_tx;
    assign busy    = w_active;
    assign done    = w_last;

endmodule
`default_nettype wire

// File: tb/tb_aucohl_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_aucohl_uart_tx
// Description : Directed self-checking bench for aucohl_uart_tx with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aucohl_uart_tx;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [PW-1:0] prescale;
    logic          parity_en;
    logic          parity_odd;
    logic          stop2;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fifo_mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 4'd1;
    end

    always #5 clk = ~clk;

    aucohl_uart_tx #(
        .DW (DW),
        .PW (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .prescale   (prescale),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    function automatic logic exp_bit(input logic [7:0] data, input logic pe, input logic po, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return data[b-1];
        if (pe && b == DW + 1) return (^data) ^ po;
        return 1'b1;
    endfunction

    task automatic wait_pop(input int budget);
        int n;
        n = 0;
        #1;
        while (fifo_rd !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        compared++;
        if (fifo_rd !== 1'b1) begin
            mismatched++;
            $display("FAIL wait_pop: fifo_rd=%b required 1 within %0d cycles", fifo_rd, budget);
        end
    endtask

    // Current cycle is the pop cycle; walks and checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] data, input logic pe, input logic po, input logic s2,
                               input int p, input logic next_pop, input int chg_k,
                               input logic [PW-1:0] chg_val);
        int nbits;
        int f;
        int b;
        logic e;
        nbits = 1 + DW + int'(pe) + 1 + int'(s2);
        f = nbits * (p + 1);
        for (int k = 1; k <= f; k++) begin
            step();
            b = (k - 1) / (p + 1);
            e = exp_bit(data, pe, po, b);
            compared++;
            if (tx !== e) begin
                mismatched++;
                $display("FAIL frame_tx data=%h cycle=%0d bit=%0d: tx=%b required %b", data, k, b, tx, e);
            end
            compared++;
            if (busy !== 1'b1) begin
                mismatched++;
                $display("FAIL frame_busy data=%h cycle=%0d: busy=%b required 1", data, k, busy);
            end
            compared++;
            if (done !== (k == f)) begin
                mismatched++;
                $display("FAIL frame_done data=%h cycle=%0d: done=%b required %b", data, k, done, k == f);
            end
            if (k == f) begin
                compared++;
                if (fifo_rd !== next_pop) begin
                    mismatched++;
                    $display("FAIL frame_next_pop data=%h: fifo_rd=%b required %b", data, fifo_rd, next_pop);
                end
            end
            if (k == chg_k) prescale = chg_val;
        end
    endtask

    task automatic check_idle(input string name);
        step();
        compared++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL %s idle: tx/busy/fifo_rd=%b%b%b required 100", name, tx, busy, fifo_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; prescale = 16'd3;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        push(8'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fifo_rd !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_state: tx/busy/done/fifo_rd=%b%b%b%b required 1000", tx, busy, done, fifo_rd);
            end
        end
    endtask

    task automatic test_basic();
        rst = 1'b0;
        wait_pop(5);
        check_frame(8'h55, 1'b0, 1'b0, 1'b0, 3, 1'b0, -1, '0);
        check_idle("basic");
    endtask

    task automatic test_parity();
        parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
        push(8'h07);
        wait_pop(5);
        check_frame(8'h07, 1'b1, 1'b0, 1'b0, 3, 1'b0, -1, '0);
        check_idle("parity_even");
        parity_odd = 1'b1;
        push(8'h07);
        wait_pop(5);
        check_frame(8'h07, 1'b1, 1'b1, 1'b0, 3, 1'b0, -1, '0);
        check_idle("parity_odd");
        parity_odd = 1'b0; stop2 = 1'b1;
        push(8'h07);
        wait_pop(5);
        check_frame(8'h07, 1'b1, 1'b0, 1'b1, 3, 1'b0, -1, '0);
        check_idle("stop2");
        parity_en = 1'b0; stop2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        prescale = 16'd0;
        push(8'hA3);
        push(8'h3C);
        wait_pop(5);
        check_frame(8'hA3, 1'b0, 1'b0, 1'b0, 0, 1'b1, -1, '0);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1, '0);
        check_idle("back_to_back");
    endtask

    task automatic test_enable();
        en = 1'b0; prescale = 16'd3;
        push(8'h5A);
        for (int i = 0; i < 50; i++) begin
            step();
            compared++;
            if (fifo_rd !== 1'b0 || tx !== 1'b1) begin
                mismatched++;
                $display("FAIL enable_low cycle=%0d: fifo_rd=%b tx=%b required 0 1", i, fifo_rd, tx);
            end
        end
        en = 1'b1;
        #1;
        compared++;
        if (fifo_rd !== 1'b1) begin
            mismatched++;
            $display("FAIL enable_rise: fifo_rd=%b required 1", fifo_rd);
        end
        check_frame(8'h5A, 1'b0, 1'b0, 1'b0, 3, 1'b0, -1, '0);
        check_idle("enable");
    endtask

    task automatic test_reset_mid();
        prescale = 16'd3;
        push(8'h96);
        push(8'hC3);
        wait_pop(5);
        for (int k = 1; k <= 18; k++) step();
        compared++;
        if (tx !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_bit3: tx=%b required 0", tx);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (fifo_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_pop: fifo_rd=%b required 0", fifo_rd);
        end
        step();
        compared++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_state: tx/busy/fifo_rd=%b%b%b required 100", tx, busy, fifo_rd);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (fifo_rd !== 1'b1 || fifo_rdata !== 8'hC3) begin
            mismatched++;
            $display("FAIL reset_mid_resume: fifo_rd=%b rdata=%h required 1 c3", fifo_rd, fifo_rdata);
        end
        check_frame(8'hC3, 1'b0, 1'b0, 1'b0, 3, 1'b0, -1, '0);
        check_idle("reset_mid");
    endtask

    task automatic test_prescale_change();
        prescale = 16'd3;
        push(8'h3C);
        push(8'h81);
        wait_pop(5);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3, 1'b1, 10, 16'd7);
        check_frame(8'h81, 1'b0, 1'b0, 1'b0, 7, 1'b0, -1, '0);
        check_idle("prescale_change");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_prescale_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
